scan_sequencer: RTL

//  Upstream driver for the 3-to-8 line decoder. Steps a 3-bit channel index over the enabled channels.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_sequencer_if.sv | 31 +++
 rtl/next_chan_finder.sv | 34 +++
 rtl/scan_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer and its channel finder.
package scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_BLANK
  } state_e;

  // True when no mask bit above s is set, i.e. leaving s wraps the scan.
  function automatic logic is_last(logic [NCH-1:0] m, logic [SEL_W-1:0] s);
    return ((m >> s) >> 1) == '0;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Config/handshake and decoder-drive bundle between a host and the scan sequencer.
interface scan_sequencer_if
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int BLANK_W = 8
);

  logic               start;
  logic               stop;
  logic               one_shot;
  logic [NCH-1:0]     chan_mask;
  logic [DWELL_W-1:0] dwell_cyc;
  logic [BLANK_W-1:0] blank_cyc;
  logic [SEL_W-1:0]   sel;
  logic               ena;
  logic               busy;
  logic               frame_done;
  logic               err_nomask;

  modport master (
    output start, stop, one_shot, chan_mask, dwell_cyc, blank_cyc,
    input  sel, ena, busy, frame_done, err_nomask
  );

  modport slave (
    input  start, stop, one_shot, chan_mask, dwell_cyc, blank_cyc,
    output sel, ena, busy, frame_done, err_nomask
  );

endinterface

// File: rtl/next_chan_finder.sv
// Combinational: next enabled channel above cur (wrapping), wrap flag, lowest enabled channel.
module next_chan_finder
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic [SEL_W-1:0] first
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SEL_W:0]   shamt;
  logic [SEL_W-1:0] off;

  // Rotate the mask so bit 0 is the channel just above cur, then priority-encode.
  always_comb begin
    dbl   = {mask, mask};
    shamt = {1'b0, cur} + (SEL_W+1)'(1);
    rot   = NCH'(dbl >> shamt);
    off   = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    nxt   = cur + off + SEL_W'(1);
    wrap  = (nxt <= cur);
    first = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (mask[k]) first = SEL_W'(k);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit decoder select over enabled channels with dwell, blanking and frame markers.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int BLANK_W = 8
)(
  input  logic            clk,
  input  logic            rst,
  scan_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               ena_q, ena_d;
  logic               busy_q, busy_d;
  logic               fdone_q, fdone_d;
  logic               err_q, err_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               oneshot_q, oneshot_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [BLANK_W-1:0] bcnt_q, bcnt_d;

  logic [SEL_W-1:0]   sh_nxt, sh_first_unused;
  logic               sh_wrap;
  logic [SEL_W-1:0]   live_first, live_nxt_unused;
  logic               live_wrap_unused;
  logic [DWELL_W-1:0] dload_sh, dload_live;
  logic               step, launch, to_idle;

  // Advance within the latched frame configuration.
  next_chan_finder u_fin_sh (
    .mask  (mask_q),
    .cur   (sel_q),
    .nxt   (sh_nxt),
    .wrap  (sh_wrap),
    .first (sh_first_unused)
  );

  // First channel of the live mask, used when a frame (re)starts.
  next_chan_finder u_fin_live (
    .mask  (bus.chan_mask),
    .cur   ('0),
    .nxt   (live_nxt_unused),
    .wrap  (live_wrap_unused),
    .first (live_first)
  );

  // Dwell of 0 behaves as 1: counter preload is dwell-1, floored at 0.
  assign dload_sh   = (dwell_q == '0)       ? '0 : dwell_q - DWELL_W'(1);
  assign dload_live = (bus.dwell_cyc == '0) ? '0 : bus.dwell_cyc - DWELL_W'(1);

  // Next-state, counters, shadow config and output lookahead.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ena_d     = ena_q;
    busy_d    = busy_q;
    fdone_d   = 1'b0;
    err_d     = 1'b0;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    oneshot_d = oneshot_q;
    dcnt_d    = dcnt_q;
    bcnt_d    = bcnt_q;
    step      = 1'b0;
    launch    = 1'b0;
    to_idle   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.chan_mask != '0) launch = 1'b1;
          else                     err_d  = 1'b1;
        end
      end
      S_DWELL: begin
        if (bus.stop)              to_idle = 1'b1;
        else if (dcnt_q != '0)     dcnt_d  = dcnt_q - DWELL_W'(1);
        else if (blank_q != '0) begin
          state_d = S_BLANK;
          ena_d   = 1'b0;
          bcnt_d  = blank_q - BLANK_W'(1);
        end
        else                       step    = 1'b1;
      end
      S_BLANK: begin
        if (bus.stop)              to_idle = 1'b1;
        else if (bcnt_q != '0)     bcnt_d  = bcnt_q - BLANK_W'(1);
        else                       step    = 1'b1;
      end
      default: to_idle = 1'b1;
    endcase

    // Leaving the current channel: next channel, or frame boundary handling.
    if (step) begin
      if (!sh_wrap) begin
        state_d = S_DWELL;
        sel_d   = sh_nxt;
        ena_d   = 1'b1;
        dcnt_d  = dload_sh;
      end else if (oneshot_q) begin
        to_idle = 1'b1;
      end else if (bus.chan_mask != '0) begin
        launch  = 1'b1;
      end else begin
        to_idle = 1'b1;
        err_d   = 1'b1;
      end
    end

    if (launch) begin
      mask_d    = bus.chan_mask;
      dwell_d   = bus.dwell_cyc;
      blank_d   = bus.blank_cyc;
      oneshot_d = bus.one_shot;
      state_d   = S_DWELL;
      sel_d     = live_first;
      ena_d     = 1'b1;
      busy_d    = 1'b1;
      dcnt_d    = dload_live;
    end

    if (to_idle) begin
      state_d = S_IDLE;
      ena_d   = 1'b0;
      busy_d  = 1'b0;
    end

    // frame_done is registered, so flag it when the upcoming cycle is the frame's last.
    fdone_d = ((state_d == S_DWELL) && (dcnt_d == '0) && (blank_d == '0) &&
               is_last(mask_d, sel_d)) ||
              ((state_d == S_BLANK) && (bcnt_d == '0) && is_last(mask_d, sel_d));
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      err_q     <= 1'b0;
      mask_q    <= '0;
      dwell_q   <= '0;
      blank_q   <= '0;
      oneshot_q <= 1'b0;
      dcnt_q    <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ena_q     <= ena_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
      oneshot_q <= oneshot_d;
      dcnt_q    <= dcnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.ena        = ena_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fdone_q;
  assign bus.err_nomask = err_q;

endmodule
